// File: rtl/acc_mc.sv
// acc_mc: multi-channel accumulator for the myfilter datapath.
//
// Holds NCH independent ACCBITS-wide two's complement accumulators selected
// by ch_in. Accepted commands update the addressed channel at the next rising
// edge; OUT and ADD_OUT also push a rounded, saturated DATABITS-wide sample
// into a single output register drained through a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   command valid
//   in_ready   command accepted when in_valid && in_ready
//   cmd_in     0 NOP, 1 CLR, 2 LOAD, 3 ADD, 4 SUB, 5 OUT, 6 ADD_OUT, 7 CLR_ALL
//   ch_in      target channel (ignored for NOP and CLR_ALL)
//   d_in       signed operand for LOAD/ADD/SUB/ADD_OUT
//   d_out      post-update value of the last addressed channel
//   ext_out    rounded, saturated output sample
//   ext_ch     channel that produced ext_out
//   ext_valid  output sample valid
//   ext_ready  downstream accepts the sample
//   ovf        sticky per-channel overflow flags
module acc_mc #(
    parameter int DATABITS = 16,
    parameter int ACCBITS  = 24,
    parameter int NCH      = 4,
    parameter int SHIFT    = 8,
    parameter int SATURATE = 1,
    localparam int CW      = $clog2(NCH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          cmd_in,
    input  logic [CW-1:0]       ch_in,
    input  logic [ACCBITS-1:0]  d_in,
    output logic [ACCBITS-1:0]  d_out,
    output logic [DATABITS-1:0] ext_out,
    output logic [CW-1:0]       ext_ch,
    output logic                ext_valid,
    input  logic                ext_ready,
    output logic [NCH-1:0]      ovf
);

    typedef enum logic [2:0] {
        CMD_NOP     = 3'd0,
        CMD_CLR     = 3'd1,
        CMD_LOAD    = 3'd2,
        CMD_ADD     = 3'd3,
        CMD_SUB     = 3'd4,
        CMD_OUT     = 3'd5,
        CMD_ADD_OUT = 3'd6,
        CMD_CLR_ALL = 3'd7
    } cmd_e;

    localparam logic [ACCBITS-1:0] ACC_MAX = {1'b0, {(ACCBITS-1){1'b1}}};
    localparam logic [ACCBITS-1:0] ACC_MIN = {1'b1, {(ACCBITS-1){1'b0}}};
    localparam logic signed [ACCBITS:0] RND = {{ACCBITS{1'b0}}, 1'b1} << (SHIFT-1);
    localparam logic signed [ACCBITS:0] OUT_MAX =
        {{(ACCBITS-DATABITS+2){1'b0}}, {(DATABITS-1){1'b1}}};
    localparam logic signed [ACCBITS:0] OUT_MIN = ~OUT_MAX;

    logic [ACCBITS-1:0]        acc [NCH];
    cmd_e                      cmd;
    logic                      accept;
    logic [ACCBITS-1:0]        cur;
    logic signed [ACCBITS:0]   sum;
    logic                      ovf_hit;
    logic [ACCBITS-1:0]        arith;
    logic [ACCBITS-1:0]        emit_src;
    logic signed [ACCBITS:0]   rounded;
    logic signed [ACCBITS:0]   shifted;
    logic [DATABITS-1:0]       scaled;

    // A full output register that is not being drained blocks every command,
    // so the upstream simply holds its command until the sample leaves.
    assign in_ready = !ext_valid || ext_ready;
    assign accept   = in_valid && in_ready;
    assign cmd      = cmd_e'(cmd_in);

    // Datapath: one extra bit catches overflow of ADD/SUB; the emitted value is
    // rounded half up, shifted arithmetically and clamped to the sample range.
    always_comb begin
        cur      = acc[ch_in];
        sum      = '0;
        arith    = '0;
        ovf_hit  = 1'b0;
        emit_src = '0;
        rounded  = '0;
        shifted  = '0;
        scaled   = '0;

        if (cmd == CMD_SUB) begin
            sum = $signed({cur[ACCBITS-1], cur}) - $signed({d_in[ACCBITS-1], d_in});
        end else begin
            sum = $signed({cur[ACCBITS-1], cur}) + $signed({d_in[ACCBITS-1], d_in});
        end
        ovf_hit = sum[ACCBITS] != sum[ACCBITS-1];
        if (ovf_hit && SATURATE != 0) begin
            arith = sum[ACCBITS] ? ACC_MIN : ACC_MAX;
        end else begin
            arith = sum[ACCBITS-1:0];
        end

        emit_src = (cmd == CMD_ADD_OUT) ? arith : cur;
        rounded  = $signed({emit_src[ACCBITS-1], emit_src}) + RND;
        shifted  = rounded >>> SHIFT;
        if (shifted > OUT_MAX) begin
            scaled = OUT_MAX[DATABITS-1:0];
        end else if (shifted < OUT_MIN) begin
            scaled = OUT_MIN[DATABITS-1:0];
        end else begin
            scaled = shifted[DATABITS-1:0];
        end
    end

    // State update. A draining sample clears ext_valid unless an output
    // command accepted in the same cycle refills the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                acc[i] <= '0;
            end
            d_out     <= '0;
            ext_out   <= '0;
            ext_ch    <= '0;
            ext_valid <= 1'b0;
            ovf       <= '0;
        end else begin
            if (ext_valid && ext_ready) begin
                ext_valid <= 1'b0;
            end
            if (accept) begin
                case (cmd)
                    CMD_CLR: begin
                        acc[ch_in] <= '0;
                        ovf[ch_in] <= 1'b0;
                        d_out      <= '0;
                    end
                    CMD_LOAD: begin
                        acc[ch_in] <= d_in;
                        d_out      <= d_in;
                    end
                    CMD_ADD, CMD_SUB: begin
                        acc[ch_in] <= arith;
                        d_out      <= arith;
                        if (ovf_hit) begin
                            ovf[ch_in] <= 1'b1;
                        end
                    end
                    CMD_OUT: begin
                        d_out     <= cur;
                        ext_out   <= scaled;
                        ext_ch    <= ch_in;
                        ext_valid <= 1'b1;
                    end
                    CMD_ADD_OUT: begin
                        acc[ch_in] <= arith;
                        d_out      <= arith;
                        if (ovf_hit) begin
                            ovf[ch_in] <= 1'b1;
                        end
                        ext_out   <= scaled;
                        ext_ch    <= ch_in;
                        ext_valid <= 1'b1;
                    end
                    CMD_CLR_ALL: begin
                        for (int i = 0; i < NCH; i++) begin
                            acc[i] <= '0;
                        end
                        ovf   <= '0;
                        d_out <= '0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_acc_mc.sv
// tb_acc_mc: directed self-checking bench for acc_mc.
//
// Two instances share all inputs: dut uses the default saturating arithmetic,
// dut_wrap uses wrapping arithmetic (SATURATE=0). Inputs change 1 time unit
// after a rising edge and outputs are sampled at the same point.
module tb_acc_mc;

    localparam logic [2:0] NOP = 3'd0, CLR = 3'd1, LOAD = 3'd2, ADD = 3'd3,
                           SUB = 3'd4, OUT = 3'd5, ADD_OUT = 3'd6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  cmd_in = 3'd0;
    logic [1:0]  ch_in = 2'd0;
    logic [23:0] d_in = 24'd0;
    logic        ext_ready = 1'b1;

    logic        in_ready, ext_valid;
    logic [23:0] d_out;
    logic [15:0] ext_out;
    logic [1:0]  ext_ch;
    logic [3:0]  ovf;

    logic        w_in_ready, w_ext_valid;
    logic [23:0] w_d_out;
    logic [15:0] w_ext_out;
    logic [1:0]  w_ext_ch;
    logic [3:0]  w_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    acc_mc dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .cmd_in(cmd_in), .ch_in(ch_in), .d_in(d_in), .d_out(d_out),
        .ext_out(ext_out), .ext_ch(ext_ch), .ext_valid(ext_valid),
        .ext_ready(ext_ready), .ovf(ovf)
    );

    acc_mc #(.SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
        .cmd_in(cmd_in), .ch_in(ch_in), .d_in(d_in), .d_out(w_d_out),
        .ext_out(w_ext_out), .ext_ch(w_ext_ch), .ext_valid(w_ext_valid),
        .ext_ready(ext_ready), .ovf(w_ovf)
    );

    always #5 clk = ~clk;

    // Present one command for exactly one edge, then drop in_valid.
    task automatic issue(input logic [2:0] c, input logic [1:0] ch, input logic [23:0] d);
        in_valid = 1'b1;
        cmd_in   = c;
        ch_in    = ch;
        d_in     = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cmd_in   = NOP;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1; cmd_in = LOAD; ch_in = 2'd0; d_in = 24'h000123;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0; cmd_in = NOP;
        n_checks++; if (d_out !== 24'h0) begin n_fail++; $display("[TB] FAIL reset_d_out got %h exp %h", d_out, 24'h0); end
        n_checks++; if (ext_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ext_valid got %b exp 0", ext_valid); end
        n_checks++; if (ovf !== 4'b0) begin n_fail++; $display("[TB] FAIL reset_ovf got %b exp 0000", ovf); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready got %b exp 1", in_ready); end
        issue(OUT, 2'd0, 24'h0);
        n_checks++; if (d_out !== 24'h0) begin n_fail++; $display("[TB] FAIL reset_load_ignored got %h exp %h", d_out, 24'h0); end
        n_checks++; if (ext_valid !== 1'b1 || ext_out !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_out_ch0 got v=%b %h exp v=1 0000", ext_valid, ext_out); end
    endtask

    task automatic test_arith();
        ext_ready = 1'b1;
        issue(LOAD, 2'd1, 24'd100);
        n_checks++; if (d_out !== 24'd100) begin n_fail++; $display("[TB] FAIL arith_load got %h exp %h", d_out, 24'd100); end
        issue(ADD, 2'd1, 24'd50);
        n_checks++; if (d_out !== 24'd150) begin n_fail++; $display("[TB] FAIL arith_add got %h exp %h", d_out, 24'd150); end
        issue(SUB, 2'd1, 24'd200);
        n_checks++; if (d_out !== 24'hFFFFCE) begin n_fail++; $display("[TB] FAIL arith_sub got %h exp FFFFCE", d_out); end
        for (int c = 0; c < 4; c++) begin
            if (c != 1) begin
                issue(OUT, 2'(c), 24'h0);
                n_checks++; if (d_out !== 24'h0) begin n_fail++; $display("[TB] FAIL arith_iso_ch%0d got %h exp 000000", c, d_out); end
            end
        end
    endtask

    task automatic test_rounding();
        issue(LOAD, 2'd0, 24'h000180);
        issue(LOAD, 2'd2, 24'h00017F);
        issue(OUT, 2'd0, 24'h0);
        n_checks++; if (ext_out !== 16'd2 || ext_ch !== 2'd0) begin n_fail++; $display("[TB] FAIL round_up_ch0 got %h ch%0d exp 0002 ch0", ext_out, ext_ch); end
        issue(OUT, 2'd2, 24'h0);
        n_checks++; if (ext_out !== 16'd1 || ext_ch !== 2'd2) begin n_fail++; $display("[TB] FAIL round_down_ch2 got %h ch%0d exp 0001 ch2", ext_out, ext_ch); end
        issue(LOAD, 2'd1, 24'hFFFE80);
        issue(OUT, 2'd1, 24'h0);
        n_checks++; if (ext_out !== 16'hFFFF || ext_ch !== 2'd1) begin n_fail++; $display("[TB] FAIL round_neg_ch1 got %h ch%0d exp FFFF ch1", ext_out, ext_ch); end
        n_checks++; if (d_out !== 24'hFFFE80) begin n_fail++; $display("[TB] FAIL round_out_d_out got %h exp FFFE80", d_out); end
    endtask

    task automatic test_saturation();
        issue(LOAD, 2'd3, 24'h7FFFF0);
        issue(ADD, 2'd3, 24'h000020);
        n_checks++; if (d_out !== 24'h7FFFFF) begin n_fail++; $display("[TB] FAIL sat_clamp got %h exp 7FFFFF", d_out); end
        n_checks++; if (ovf !== 4'b1000) begin n_fail++; $display("[TB] FAIL sat_ovf got %b exp 1000", ovf); end
        n_checks++; if (w_d_out !== 24'h800010) begin n_fail++; $display("[TB] FAIL wrap_value got %h exp 800010", w_d_out); end
        n_checks++; if (w_ovf !== 4'b1000) begin n_fail++; $display("[TB] FAIL wrap_ovf got %b exp 1000", w_ovf); end
        issue(OUT, 2'd3, 24'h0);
        n_checks++; if (ext_out !== 16'h7FFF) begin n_fail++; $display("[TB] FAIL sat_out_clamp got %h exp 7FFF", ext_out); end
        n_checks++; if (w_ext_out !== 16'h8000) begin n_fail++; $display("[TB] FAIL wrap_out got %h exp 8000", w_ext_out); end
        n_checks++; if (ovf !== 4'b1000) begin n_fail++; $display("[TB] FAIL sat_ovf_sticky got %b exp 1000", ovf); end
        issue(CLR, 2'd3, 24'h0);
        n_checks++; if (ovf !== 4'b0 || w_ovf !== 4'b0) begin n_fail++; $display("[TB] FAIL sat_clr_ovf got %b/%b exp 0000/0000", ovf, w_ovf); end
        n_checks++; if (d_out !== 24'h0) begin n_fail++; $display("[TB] FAIL sat_clr_d_out got %h exp 000000", d_out); end
    endtask

    task automatic test_backpressure();
        ext_ready = 1'b0;
        issue(OUT, 2'd1, 24'h0);
        n_checks++; if (ext_valid !== 1'b1 || ext_out !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL bp_out got v=%b %h exp v=1 FFFF", ext_valid, ext_out); end
        in_valid = 1'b1; cmd_in = ADD; ch_in = 2'd1; d_in = 24'd5;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_in_ready_c%0d got %b exp 0", k, in_ready); end
            @(posedge clk);
            #1;
            n_checks++; if (ext_valid !== 1'b1 || ext_out !== 16'hFFFF || ext_ch !== 2'd1) begin n_fail++; $display("[TB] FAIL bp_hold_c%0d got v=%b %h ch%0d exp v=1 FFFF ch1", k, ext_valid, ext_out, ext_ch); end
            n_checks++; if (d_out !== 24'hFFFE80) begin n_fail++; $display("[TB] FAIL bp_stalled_c%0d got %h exp FFFE80", k, d_out); end
        end
        ext_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_release_ready got %b exp 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0; cmd_in = NOP;
        n_checks++; if (d_out !== 24'hFFFE85) begin n_fail++; $display("[TB] FAIL bp_add_accepted got %h exp FFFE85", d_out); end
        n_checks++; if (ext_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_drained got %b exp 0", ext_valid); end
    endtask

    task automatic test_back_to_back();
        ext_ready = 1'b1;
        issue(LOAD, 2'd0, 24'h0);
        in_valid = 1'b1; cmd_in = ADD_OUT; ch_in = 2'd0; d_in = 24'h000100;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            n_checks++; if (ext_valid !== 1'b1 || ext_out !== 16'(k) || ext_ch !== 2'd0) begin n_fail++; $display("[TB] FAIL b2b_sample%0d got v=%b %h exp v=1 %h", k, ext_valid, ext_out, 16'(k)); end
            n_checks++; if (d_out !== 24'(k * 256) || in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_acc%0d got %h rdy=%b exp %h rdy=1", k, d_out, in_ready, 24'(k * 256)); end
        end
        in_valid = 1'b0; cmd_in = NOP;
        @(posedge clk);
        #1;
        // Stall a fresh sample, then reset in the middle of the stall.
        ext_ready = 1'b0;
        issue(OUT, 2'd1, 24'h0);
        n_checks++; if (ext_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_before_rst got %b exp 1", ext_valid); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++; if (ext_valid !== 1'b0 || d_out !== 24'h0 || ovf !== 4'b0) begin n_fail++; $display("[TB] FAIL mid_stall_rst got v=%b %h %b exp v=0 000000 0000", ext_valid, d_out, ovf); end
        ext_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            issue(OUT, 2'(c), 24'h0);
            n_checks++; if (d_out !== 24'h0 || ext_out !== 16'h0) begin n_fail++; $display("[TB] FAIL rst_cleared_ch%0d got %h/%h exp 000000/0000", c, d_out, ext_out); end
        end
    endtask

    initial begin
        $display("[TB] starting acc_mc bench");
        test_reset();
        test_arith();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
